core_trace_capture: RTL and testbench

Capture engine for retired-instruction trace on cores that retire up to RETIRE_W instructions per cycle. It qualifies commit-stage lanes, optionally waits for a PC trigger, timestamps each retired lane and buffers it as a record. Records drain through a valid/ready port toward the trace sink or debug bus. It generalises the single-lane core monitor trace into a parametrised, buffered, triggerable block that sits beside each hart.

---
 rtl/core_trace_pkg.sv | 48 ++++
 rtl/core_trace_fifo.sv | 55 +++++
 rtl/core_trace_capture.sv | 244 ++++++++++++++++++++++++
 tb/tb_core_trace_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_trace_pkg.sv
// Shared types for the retired-instruction trace capture engine.
// Holds the state encoding, record layout and flag bit positions.
package core_trace_pkg;

    typedef enum logic [1:0] {
        TS_IDLE    = 2'd0,
        TS_ARMED   = 2'd1,
        TS_CAPTURE = 2'd2,
        TS_DONE    = 2'd3
    } trace_state_e;

    localparam int TRACE_XLEN = 32;
    localparam int TRACE_TS_W = 16;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
        logic [TRACE_XLEN-1:0] wdata;
        logic [4:0]            rd;
        logic [TRACE_TS_W-1:0] ts;
        logic [5:0]            flags;
    } trace_rec_t;

    localparam int FLAG_GAP     = 5;
    localparam int FLAG_EXC     = 4;
    localparam int FLAG_IRQ     = 3;
    localparam int FLAG_WEN     = 2;
    localparam int FLAG_MODE_HI = 1;
    localparam int FLAG_MODE_LO = 0;

    function automatic logic [5:0] pack_flags(
        input logic       gap,
        input logic       exc,
        input logic       irq,
        input logic       wen,
        input logic [1:0] mode
    );
        logic [5:0] f;
        f = '0;
        f[FLAG_GAP] = gap;
        f[FLAG_EXC] = exc;
        f[FLAG_IRQ] = irq;
        f[FLAG_WEN] = wen;
        f[FLAG_MODE_HI:FLAG_MODE_LO] = mode;
        return f;
    endfunction

endpackage

// File: rtl/core_trace_fifo.sv
// Multi-write, single-read record FIFO for the trace capture engine.
// Up to NPORT compacted records are written per cycle in port order.
module core_trace_fifo
    import core_trace_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int NPORT = 2,
    parameter int NW    = $clog2(NPORT + 1),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NW-1:0]             wr_cnt,
    input  logic [NPORT-1:0][W-1:0]   wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [W-1:0]              rd_data,
    output logic [CW-1:0]             count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          rd_fire;

    assign rd_valid = (count != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    // Store the first wr_cnt ports at consecutive slots from the write pointer.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NPORT; p++) begin
            if (NW'(p) < wr_cnt) begin
                mem[wptr + AW'(p)] <= wr_data[p];
            end
        end
    end

    // Advance pointers and occupancy; a read and writes may share a cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_cnt);
            rptr  <= rptr + AW'(rd_fire);
            count <= count - CW'(rd_fire) + CW'(wr_cnt);
        end
    end

endmodule

// File: rtl/core_trace_capture.sv
// Retired-instruction trace capture: lane qualification, PC trigger,
// record limit, timestamping and buffering toward a valid/ready sink.
module core_trace_capture
    import core_trace_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 2,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [RETIRE_W-1:0]      commit,
    input  logic [RETIRE_W*XLEN-1:0] pc,
    input  logic [RETIRE_W*XLEN-1:0] instruction,
    input  logic [RETIRE_W-1:0]      exception,
    input  logic [RETIRE_W-1:0]      interrupt_fire,
    input  logic [RETIRE_W-1:0]      rd_wenx,
    input  logic [RETIRE_W*3-1:0]    mode,
    input  logic [RETIRE_W*5-1:0]    rd_waddr,
    input  logic [RETIRE_W*XLEN-1:0] rd_wdata,
    input  logic                     cfg_enable,
    input  logic                     cfg_trig_en,
    input  logic [XLEN-1:0]          cfg_trig_pc,
    input  logic                     cfg_skip_debug,
    input  logic [15:0]              cfg_stop_after,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [XLEN-1:0]          rec_pc,
    output logic [XLEN-1:0]          rec_instr,
    output logic [XLEN-1:0]          rec_wdata,
    output logic [4:0]               rec_rd,
    output logic [TS_W-1:0]          rec_ts,
    output logic [5:0]               rec_flags,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              drop_count
);

    localparam int NW    = $clog2(RETIRE_W + 1);
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int REC_W = 3 * XLEN + 5 + TS_W + 6;

    localparam logic [1:0] S_IDLE    = 2'(TS_IDLE);
    localparam logic [1:0] S_ARMED   = 2'(TS_ARMED);
    localparam logic [1:0] S_CAPTURE = 2'(TS_CAPTURE);
    localparam logic [1:0] S_DONE    = 2'(TS_DONE);

    logic [1:0]      state_q;
    logic            trig_en_q;
    logic [XLEN-1:0] trig_pc_q;
    logic            skip_q;
    logic [15:0]     stop_q;
    logic [15:0]     rec_cnt_q;
    logic [TS_W-1:0] ts_q;
    logic            gap_q;
    logic [15:0]     drop_q;

    logic                leave_idle;
    logic                active;
    logic [15:0]         remaining;
    logic [RETIRE_W-1:0] elig;
    logic [RETIRE_W-1:0] cand;
    logic [RETIRE_W-1:0] take;
    logic [NW-1:0]       pre [RETIRE_W];
    logic [NW-1:0]       n_take;
    logic [NW-1:0]       cnt;
    logic                seen;
    logic                hit_any;
    logic                trig_hit;
    logic                fits;
    logic                do_write;
    logic                do_drop;
    logic                hit_limit;

    logic [NW-1:0]                  wr_cnt;
    logic [RETIRE_W-1:0][REC_W-1:0] wr_data;
    logic [REC_W-1:0]               rd_data;

    assign leave_idle = (state_q == S_IDLE) && cfg_enable;
    assign active     = cfg_enable
                        && (state_q == S_ARMED || state_q == S_CAPTURE);
    assign remaining  = stop_q - rec_cnt_q;

    // Qualify lanes, apply the trigger window and trim to the record limit.
    always_comb begin
        elig    = '0;
        cand    = '0;
        take    = '0;
        hit_any = 1'b0;
        cnt     = '0;
        seen    = (state_q == S_CAPTURE);
        for (int i = 0; i < RETIRE_W; i++) begin
            pre[i]  = '0;
        end
        for (int i = 0; i < RETIRE_W; i++) begin
            elig[i] = commit[i] && !(skip_q && mode[i*3+2]);
            if (state_q == S_ARMED && elig[i]
                && pc[i*XLEN +: XLEN] == trig_pc_q) begin
                seen    = 1'b1;
                hit_any = 1'b1;
            end
            cand[i] = elig[i] && seen && active;
            pre[i]  = cnt;
            if (cand[i] && (stop_q == '0 || 16'(cnt) < remaining)) begin
                take[i] = 1'b1;
                cnt     = cnt + NW'(1);
            end
        end
        n_take = cnt;
    end

    assign trig_hit  = hit_any && cfg_enable;
    assign fits      = (32'(occupancy) + 32'(n_take)) <= 32'(DEPTH);
    assign do_write  = (n_take != '0) && fits;
    assign do_drop   = (n_take != '0) && !fits;
    assign hit_limit = do_write && (stop_q != '0)
                       && (rec_cnt_q + 16'(n_take) == stop_q);
    assign wr_cnt    = do_write ? n_take : '0;

    // Compact taken lanes onto write ports, oldest lane on port 0.
    always_comb begin
        wr_data = '0;
        for (int p = 0; p < RETIRE_W; p++) begin
            for (int i = 0; i < RETIRE_W; i++) begin
                if (take[i] && pre[i] == NW'(p)) begin
                    wr_data[p] = {
                        pc[i*XLEN +: XLEN],
                        instruction[i*XLEN +: XLEN],
                        rd_wdata[i*XLEN +: XLEN],
                        rd_waddr[i*5 +: 5],
                        ts_q,
                        pack_flags(gap_q && (pre[i] == '0),
                                   exception[i],
                                   interrupt_fire[i],
                                   rd_wenx[i],
                                   mode[i*3 +: 2])
                    };
                end
            end
        end
    end

    // Capture state machine; disabling returns to IDLE from anywhere.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else if (!cfg_enable) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_q <= cfg_trig_en ? S_ARMED : S_CAPTURE;
                S_ARMED: begin
                    if (trig_hit) begin
                        state_q <= hit_limit ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (hit_limit) begin
                        state_q <= S_DONE;
                    end
                end
                default:   state_q <= state_q;
            endcase
        end
    end

    // Snapshot configuration when leaving IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trig_en_q <= 1'b0;
            trig_pc_q <= '0;
            skip_q    <= 1'b0;
            stop_q    <= '0;
        end else if (leave_idle) begin
            trig_en_q <= cfg_trig_en;
            trig_pc_q <= cfg_trig_pc;
            skip_q    <= cfg_skip_debug;
            stop_q    <= cfg_stop_after;
        end
    end

    // Free-running timestamp, restarted on each IDLE exit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else if (leave_idle) begin
            ts_q <= '0;
        end else if (state_q != S_IDLE) begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    // Records written since arming; cleared whenever IDLE is reached.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rec_cnt_q <= '0;
        end else if (!cfg_enable || state_q == S_IDLE) begin
            rec_cnt_q <= '0;
        end else if (do_write) begin
            rec_cnt_q <= rec_cnt_q + 16'(n_take);
        end
    end

    // Drop accounting and the gap marker for the next written record.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
            gap_q  <= 1'b0;
        end else if (leave_idle) begin
            drop_q <= '0;
            gap_q  <= 1'b0;
        end else if (do_drop) begin
            gap_q <= 1'b1;
            if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end else if (do_write) begin
            gap_q <= 1'b0;
        end
    end

    core_trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH),
        .NPORT (RETIRE_W),
        .NW    (NW),
        .CW    (CW)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_cnt   (wr_cnt),
        .wr_data  (wr_data),
        .rd_valid (rec_valid),
        .rd_ready (rec_ready),
        .rd_data  (rd_data),
        .count    (occupancy)
    );

    assign {rec_pc, rec_instr, rec_wdata, rec_rd, rec_ts, rec_flags} = rd_data;
    assign state      = state_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_core_trace_capture.sv
// Scoreboard bench for core_trace_capture (RETIRE_W=2, DEPTH=4).
// Expected records are queued at drive time and popped on each transfer.
module tb_core_trace_capture;

    logic        clock;
    logic        reset_n;
    logic [1:0]  commit;
    logic [63:0] pc;
    logic [63:0] instruction;
    logic [1:0]  exception;
    logic [1:0]  interrupt_fire;
    logic [1:0]  rd_wenx;
    logic [5:0]  mode;
    logic [9:0]  rd_waddr;
    logic [63:0] rd_wdata;
    logic        cfg_enable;
    logic        cfg_trig_en;
    logic [31:0] cfg_trig_pc;
    logic        cfg_skip_debug;
    logic [15:0] cfg_stop_after;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_pc;
    logic [31:0] rec_instr;
    logic [31:0] rec_wdata;
    logic [4:0]  rec_rd;
    logic [15:0] rec_ts;
    logic [5:0]  rec_flags;
    logic [1:0]  state;
    logic [2:0]  occupancy;
    logic [15:0] drop_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [15:0] ts;
        logic [5:0]  flags;
    } exp_rec_t;

    exp_rec_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int en_cyc = 0;

    core_trace_capture #(
        .XLEN(32), .RETIRE_W(2), .DEPTH(4), .TS_W(16)
    ) dut (
        .clock(clock), .reset_n(reset_n), .commit(commit), .pc(pc),
        .instruction(instruction), .exception(exception),
        .interrupt_fire(interrupt_fire), .rd_wenx(rd_wenx), .mode(mode),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .cfg_enable(cfg_enable), .cfg_trig_en(cfg_trig_en),
        .cfg_trig_pc(cfg_trig_pc), .cfg_skip_debug(cfg_skip_debug),
        .cfg_stop_after(cfg_stop_after), .rec_valid(rec_valid),
        .rec_ready(rec_ready), .rec_pc(rec_pc), .rec_instr(rec_instr),
        .rec_wdata(rec_wdata), .rec_rd(rec_rd), .rec_ts(rec_ts),
        .rec_flags(rec_flags), .state(state), .occupancy(occupancy),
        .drop_count(drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop and compare one expected record per transfer.
    always @(negedge clock) begin
        if (reset_n && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_extra", 64'(rec_valid), 64'd0);
            end else begin
                exp_rec_t e;
                e = exp_q.pop_front();
                check_eq("rec_pc", 64'(rec_pc), 64'(e.pc));
                check_eq("rec_instr", 64'(rec_instr), 64'(e.instr));
                check_eq("rec_wdata", 64'(rec_wdata), 64'(e.wdata));
                check_eq("rec_rd", 64'(rec_rd), 64'(e.rd));
                check_eq("rec_ts", 64'(rec_ts), 64'(e.ts));
                check_eq("rec_flags", 64'(rec_flags), 64'(e.flags));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start(input logic te, input logic [31:0] tpc,
                         input logic sk, input logic [15:0] stop,
                         input logic rdy);
        cfg_enable = 1'b0;
        tick(1);
        cfg_trig_en    = te;
        cfg_trig_pc    = tpc;
        cfg_skip_debug = sk;
        cfg_stop_after = stop;
        rec_ready      = rdy;
        cfg_enable     = 1'b1;
        en_cyc         = cyc + 1;
        tick(1);
    endtask

    // Drive one commit cycle; em marks lanes the bench expects captured.
    task automatic drive(input logic [1:0] cm, input logic [31:0] p0,
                         input logic [31:0] p1, input logic [2:0] m0,
                         input logic [2:0] m1, input logic [1:0] em,
                         input logic g);
        logic [31:0] pv [2];
        logic [2:0]  mv [2];
        logic        first;
        exp_rec_t    e;
        pv[0] = p0;
        pv[1] = p1;
        mv[0] = m0;
        mv[1] = m1;
        commit         = cm;
        pc             = {p1, p0};
        instruction    = {p1 ^ 32'h13, p0 ^ 32'h13};
        rd_wdata       = {p1 + 32'd1, p0 ^ 32'hdead};
        mode           = {m1, m0};
        exception      = 2'b10;
        interrupt_fire = 2'b01;
        rd_wenx        = 2'b01;
        rd_waddr       = {5'd7, 5'd3};
        first = g;
        for (int l = 0; l < 2; l++) begin
            if (em[l]) begin
                e.pc    = pv[l];
                e.instr = pv[l] ^ 32'h13;
                e.wdata = (l == 0) ? (pv[l] ^ 32'hdead) : (pv[l] + 32'd1);
                e.rd    = (l == 0) ? 5'd3 : 5'd7;
                e.ts    = 16'(cyc - en_cyc);
                e.flags = {first, exception[l], interrupt_fire[l],
                           rd_wenx[l], mv[l][1:0]};
                exp_q.push_back(e);
                first = 1'b0;
            end
        end
        tick(1);
        commit = 2'b00;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        commit = '0; pc = '0; instruction = '0; rd_wdata = '0;
        exception = '0; interrupt_fire = '0; rd_wenx = '0;
        mode = '0; rd_waddr = '0;
        cfg_enable = 1'b0; cfg_trig_en = 1'b0; cfg_trig_pc = '0;
        cfg_skip_debug = 1'b0; cfg_stop_after = '0; rec_ready = 1'b1;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_state", 64'(state), 64'd0);
        check_eq("rst_valid", 64'(rec_valid), 64'd0);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst_drop", 64'(drop_count), 64'd0);
        check_eq("rst_pc", 64'(rec_pc), 64'd0);
        check_eq("rst_ts", 64'(rec_ts), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Two lanes, no trigger
        start(1'b0, 32'h0, 1'b0, 16'd0, 1'b1);
        check_eq("t1_state", 64'(state), 64'd2);
        drive(2'b11, 32'h100, 32'h104, 3'b011, 3'b001, 2'b11, 1'b0);
        wait_drain(20);

        // PC trigger on lane 1, config changes after arming ignored
        start(1'b1, 32'h204, 1'b0, 16'd0, 1'b1);
        check_eq("t2_armed", 64'(state), 64'd1);
        cfg_trig_pc = 32'h999;
        drive(2'b11, 32'h1f0, 32'h1f4, 3'b000, 3'b000, 2'b00, 1'b0);
        check_eq("t2_still_armed", 64'(state), 64'd1);
        drive(2'b11, 32'h200, 32'h204, 3'b000, 3'b000, 2'b10, 1'b0);
        check_eq("t2_capture", 64'(state), 64'd2);
        wait_drain(20);

        // Backpressure, full-cycle drop, gap marker, fill to DEPTH
        start(1'b0, 32'h0, 1'b0, 16'd0, 1'b0);
        drive(2'b11, 32'h300, 32'h304, 3'b000, 3'b000, 2'b11, 1'b0);
        drive(2'b01, 32'h308, 32'h30c, 3'b000, 3'b000, 2'b01, 1'b0);
        check_eq("t3_occ3", 64'(occupancy), 64'd3);
        check_eq("t3_hold0", 64'(rec_pc), 64'h300);
        tick(1);
        check_eq("t3_hold1", 64'(rec_pc), 64'h300);
        drive(2'b11, 32'h310, 32'h314, 3'b000, 3'b000, 2'b00, 1'b0);
        check_eq("t3_drop", 64'(drop_count), 64'd1);
        check_eq("t3_occ_kept", 64'(occupancy), 64'd3);
        drive(2'b01, 32'h318, 32'h31c, 3'b010, 3'b000, 2'b01, 1'b1);
        check_eq("t3_occ_full", 64'(occupancy), 64'd4);
        rec_ready = 1'b1;
        wait_drain(20);

        // Record limit of 3
        start(1'b0, 32'h0, 1'b0, 16'd3, 1'b1);
        check_eq("t4_drop_clr", 64'(drop_count), 64'd0);
        drive(2'b11, 32'h400, 32'h404, 3'b001, 3'b010, 2'b11, 1'b0);
        drive(2'b11, 32'h408, 32'h40c, 3'b000, 3'b000, 2'b01, 1'b0);
        check_eq("t4_done", 64'(state), 64'd3);
        drive(2'b11, 32'h410, 32'h414, 3'b000, 3'b000, 2'b00, 1'b0);
        check_eq("t4_no_drop", 64'(drop_count), 64'd0);
        wait_drain(20);
        tick(3);

        // Debug-mode filtering, including for the trigger
        start(1'b1, 32'h500, 1'b1, 16'd0, 1'b1);
        check_eq("t5_armed", 64'(state), 64'd1);
        drive(2'b11, 32'h500, 32'h504, 3'b111, 3'b000, 2'b00, 1'b0);
        check_eq("t5_no_trig", 64'(state), 64'd1);
        drive(2'b11, 32'h508, 32'h500, 3'b111, 3'b000, 2'b10, 1'b0);
        check_eq("t5_trig", 64'(state), 64'd2);
        drive(2'b11, 32'h510, 32'h514, 3'b111, 3'b001, 2'b10, 1'b0);
        wait_drain(20);
        tick(3);

        // Asynchronous reset with records pending
        start(1'b0, 32'h0, 1'b0, 16'd0, 1'b0);
        drive(2'b11, 32'h600, 32'h604, 3'b000, 3'b000, 2'b00, 1'b0);
        check_eq("t6_occ2", 64'(occupancy), 64'd2);
        check_eq("t6_valid", 64'(rec_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_state", 64'(state), 64'd0);
        check_eq("t6_valid0", 64'(rec_valid), 64'd0);
        check_eq("t6_occ0", 64'(occupancy), 64'd0);
        check_eq("t6_pc0", 64'(rec_pc), 64'd0);
        check_eq("sb_left", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
